// File: rtl/pc_unit.sv
// Program counter with prioritised load/branch/increment and a circular return-address stack.
// One action per cycle; clr (synchronous) overrides everything, stall freezes all other state.
module pc_unit #(
  parameter int unsigned     WIDTH     = 32,
  parameter int unsigned     STEP      = 1,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] D,
  input  logic             wr,
  input  logic             conFFen,
  input  logic             conFFwr,
  input  logic             rel,
  input  logic             call,
  input  logic             ret,
  input  logic             inc,
  input  logic             stall,
  output logic [WIDTH-1:0] Q,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_unf
);

  localparam int unsigned     PtrW    = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] StepW   = WIDTH'(STEP);
  localparam logic [PtrW:0]    FullCnt = (PtrW + 1)'(RAS_DEPTH);

  logic [WIDTH-1:0] q_q, q_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [PtrW:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push;
  logic [WIDTH-1:0] ret_addr;
  logic [WIDTH-1:0] mem_q [RAS_DEPTH];

  assign ret_addr = q_q + StepW;

  always_comb begin
    q_d   = q_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (stall) begin
      // hold everything
    end else if (wr) begin
      q_d = D;
    end else if (conFFen && conFFwr) begin
      q_d = D;
    end else if (rel) begin
      q_d = q_q + D;
    end else if (call) begin
      q_d   = D;
      push  = 1'b1;
      ptr_d = ptr_q + 1'b1;
      // A full stack wraps onto its oldest entry, so count saturates.
      if (cnt_q == FullCnt) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (ret) begin
      if (cnt_q == '0) begin
        unf_d = 1'b1;
      end else begin
        q_d   = mem_q[ptr_q];
        ptr_d = ptr_q - 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
    end else if (inc) begin
      q_d = q_q + StepW;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q_q   <= RESET_VEC;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack storage needs no reset; contents are don't-care once count is zero.
  always_ff @(posedge clk) begin
    if (!clr && push) begin
      mem_q[ptr_d] <= ret_addr;
    end
  end

  assign Q         = q_q;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == FullCnt);
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus random traffic against a queue-based reference model.
module tb_pc_unit;

  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        clr, wr, conFFen, conFFwr, rel, call, ret, inc, stall;
  logic [31:0] D;
  logic [31:0] Q;
  logic        ras_empty, ras_full, ras_ovf, ras_unf;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  logic [31:0] m_q;
  logic [31:0] m_stk[$];
  logic        m_ovf, m_unf;

  pc_unit #(
    .WIDTH    (32),
    .STEP     (1),
    .RESET_VEC(32'h0),
    .RAS_DEPTH(Depth)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .D        (D),
    .wr       (wr),
    .conFFen  (conFFen),
    .conFFwr  (conFFwr),
    .rel      (rel),
    .call     (call),
    .ret      (ret),
    .inc      (inc),
    .stall    (stall),
    .Q        (Q),
    .ras_empty(ras_empty),
    .ras_full (ras_full),
    .ras_ovf  (ras_ovf),
    .ras_unf  (ras_unf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    if (clr) begin
      m_q = 32'h0;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (stall) begin
    end else if (wr || (conFFen && conFFwr)) begin
      m_q = D;
    end else if (rel) begin
      m_q = m_q + D;
    end else if (call) begin
      m_stk.push_back(m_q + 32'd1);
      if (m_stk.size() > Depth) begin
        void'(m_stk.pop_front());
        m_ovf = 1'b1;
      end
      m_q = D;
    end else if (ret) begin
      if (m_stk.size() == 0) m_unf = 1'b1;
      else m_q = m_stk.pop_back();
    end else if (inc) begin
      m_q = m_q + 32'd1;
    end
  endtask

  // Apply one cycle of inputs, advance model and compare every output.
  task automatic cyc(input logic c_clr, input logic c_stall, input logic c_wr, input logic c_en,
                     input logic c_fl, input logic c_rel, input logic c_call, input logic c_ret,
                     input logic c_inc, input logic [31:0] c_d);
    clr = c_clr; stall = c_stall; wr = c_wr; conFFen = c_en; conFFwr = c_fl;
    rel = c_rel; call = c_call; ret = c_ret; inc = c_inc; D = c_d;
    @(posedge clk);
    model_step();
    #1;
    check_eq("Q", Q, m_q);
    check_eq("ras_empty", 32'(ras_empty), 32'(m_stk.size() == 0));
    check_eq("ras_full", 32'(ras_full), 32'(m_stk.size() == Depth));
    check_eq("ras_ovf", 32'(ras_ovf), 32'(m_ovf));
    check_eq("ras_unf", 32'(ras_unf), 32'(m_unf));
  endtask

  initial begin
    m_q = '0; m_ovf = 1'b0; m_unf = 1'b0;
    clr = 1'b1; stall = 0; wr = 0; conFFen = 0; conFFwr = 0;
    rel = 0; call = 0; ret = 0; inc = 0; D = '0;

    // Reset, increments, wr beats inc
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    check_eq("reset_q", Q, 32'h0);
    check_eq("reset_empty", 32'(ras_empty), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
      check_eq("inc_seq", Q, 32'(i));
    end
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h100);
    check_eq("wr_over_inc", Q, 32'h100);

    // Conditional branch and relative
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h10);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h40);
    check_eq("cond_not_taken", Q, 32'h11);
    cyc(0, 0, 0, 1, 1, 0, 0, 0, 0, 32'h40);
    check_eq("cond_taken", Q, 32'h40);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFF0);
    check_eq("rel_neg", Q, 32'h30);

    // call/ret/underflow
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h20);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h80);
    check_eq("call_q", Q, 32'h80);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
    check_eq("ret_q", Q, 32'h21);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
    check_eq("unf_q", Q, 32'h21);
    check_eq("unf_flag", 32'(ras_unf), 32'd1);

    // Overflow with five nested calls
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    for (int i = 1; i <= 5; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 32'(i * 16));
    check_eq("ovf_full", 32'(ras_full), 32'd1);
    check_eq("ovf_flag", 32'(ras_ovf), 32'd1);
    for (int i = 4; i >= 1; i--) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
      check_eq("ret_chain", Q, 32'(i * 16 + 1));
    end
    check_eq("ret_chain_empty", 32'(ras_empty), 32'd1);

    // Wrap and stall
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
    check_eq("inc_wrap", Q, 32'h0);
    cyc(0, 1, 1, 0, 0, 0, 1, 0, 0, 32'h1234);
    check_eq("stall_q", Q, 32'h0);
    check_eq("stall_empty", 32'(ras_empty), 32'd1);

    // clr overrides call and stall
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h200);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h300);
    cyc(1, 1, 0, 0, 0, 0, 1, 0, 0, 32'h400);
    check_eq("clr_q", Q, 32'h0);
    check_eq("clr_empty", 32'(ras_empty), 32'd1);
    check_eq("clr_ovf", 32'(ras_ovf), 32'd0);
    check_eq("clr_unf", 32'(ras_unf), 32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] rd;
      rd = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) - 32'd8 : $urandom;
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 32, PC and data width in bits (>=8).
REQ-002 Parameter STEP, default 1, increment added on inc and pushed by call.
REQ-003 Parameter RESET_VEC, default 0, value loaded into Q on clr.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of 2, >=2).
REQ-005 clk  input  1  single clock; all state changes on posedge clk only.
REQ-006 clr  input  1  reset, synchronous and active-high.
REQ-007 D  input  WIDTH  target address (wr, conditional, call) or signed offset (rel).
REQ-008 wr  input  1  unconditional absolute load request.
REQ-009 conFFen  input  1  conditional-branch enable.
REQ-010 conFFwr  input  1  condition-flag result; branch taken only when conFFen=1.
REQ-011 rel  input  1  relative branch request, Q plus D.
REQ-012 call  input  1  push return address, load D.
REQ-013 ret  input  1  pop return address into Q.
REQ-014 inc  input  1  advance Q by STEP.
REQ-015 stall  input  1  freeze all state.
REQ-016 Q  output  WIDTH  current program counter, registered.
REQ-017 ras_empty  output  1  stack holds 0 entries, registered.
REQ-018 ras_full  output  1  stack holds RAS_DEPTH entries, registered.
REQ-019 ras_ovf  output  1  sticky: a push overwrote an entry.
REQ-020 ras_unf  output  1  sticky: ret issued on empty stack.

Function
REQ-021 Exactly one action per cycle, priority: clr > stall > wr > (conFFen&conFFwr) > rel > call > ret > inc > hold.
REQ-022 Q updates at the posedge where the action is sampled; the new value is visible the following cycle (1-cycle latency), with no deferred or pending actions.
REQ-023 wr: Q <= D.
REQ-024 Conditional branch: Q <= D when conFFen=1 and conFFwr=1; conFFen=1 with conFFwr=0 is not an action and lower-priority requests proceed.
REQ-025 rel: Q <= Q + D, two's-complement, modulo 2^WIDTH.
REQ-026 inc: Q <= Q + STEP modulo 2^WIDTH; Q = 2^WIDTH-STEP wraps to 0.
REQ-027 call: push (Q + STEP) mod 2^WIDTH onto stack; Q <= D.
REQ-028 Stack is circular with RAS_DEPTH entries, a top pointer, and a count 0..RAS_DEPTH.
REQ-029 call when full: overwrite oldest entry, advance pointer, count stays RAS_DEPTH, ras_ovf <= 1.
REQ-030 ret when non-empty: Q <= top entry, pointer retreats, count decrements.
REQ-031 ret when empty: Q holds, stack unchanged, ras_unf <= 1.
REQ-032 Losing requests in a cycle are discarded, not queued; a lower-priority stack operation does not touch the stack.
REQ-033 stall=1: Q, stack, count and flags all hold; only clr overrides stall.
REQ-034 ras_empty = (count==0), ras_full = (count==RAS_DEPTH), both derived from registered count.
REQ-035 ras_ovf and ras_unf stay set until clr.

Reset
REQ-036 clr=1 at posedge: Q <= RESET_VEC, count <= 0, pointer <= 0, ras_ovf <= 0, ras_unf <= 0, regardless of any other input, including mid call/ret sequence.
REQ-037 After clr: ras_empty=1, ras_full=0; stack entry contents are don't-care.
REQ-038 Power-up before first clr is undefined; the bench applies clr first.

Verification
REQ-039 clr, then inc x3 (WIDTH=32, STEP=1) -> Q = 0,1,2,3 on successive cycles; wr+inc same cycle with D=0x100 -> Q=0x100.
REQ-040 Q=0x10, conFFen=1 conFFwr=0, inc=1 -> Q=0x11; conFFen=1 conFFwr=1, D=0x40 -> Q=0x40; rel with D=0xFFFFFFF0 -> Q=0x30.
REQ-041 Q=0x20, call D=0x80 -> Q=0x80, ras_empty=0; ret -> Q=0x21, ras_empty=1; second ret -> Q=0x21, ras_unf=1.
REQ-042 RAS_DEPTH=4: five calls from Q=0,0x10,0x20,0x30,0x40 (D=next) -> ras_full=1, ras_ovf=1; four rets yield 0x41,0x31,0x21,0x11, then ras_empty=1.
REQ-043 Q=0xFFFFFFFF, inc -> Q=0; stall=1 with wr, call -> Q, stack and flags unchanged.
REQ-044 Two calls, then clr with call=1 and stall=1 -> Q=RESET_VEC, ras_empty=1, ras_ovf=0, ras_unf=0.
